// File: rtl/ov7670_capture_win.sv
// OV7670 byte-stream capture: pixel assembly, format decode, decimation, clipping, frame sync.
// Define CAP_TEST_PATTERN_EN to replace sensor pixel data with a {col,row,8'h5A} pattern.
module ov7670_capture_win #(
    parameter int SENSOR_WIDTH  = 640,
    parameter int SENSOR_HEIGHT = 480,
    parameter int IMG_WIDTH     = 320,
    parameter int IMG_HEIGHT    = 240,
    parameter int X_DECIM_LOG2  = 1,
    parameter int Y_DECIM_LOG2  = 1,
    parameter int ADDR_WIDTH    = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                  pclk,
    input  logic                  reset_n,
    input  logic                  cap_en,
    input  logic [1:0]            fmt,
    input  logic                  href,
    input  logic                  vsync,
    input  logic [7:0]            data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [23:0]           wData,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_line
);

    // x saturates one past the line length so over-long lines stay detectable
    localparam int XW = $clog2(SENSOR_WIDTH + 2);
    localparam int YW = $clog2(SENSOR_HEIGHT + 1);
    localparam int BW = ADDR_WIDTH + 1;

    localparam logic [XW-1:0] X_LEN    = XW'(SENSOR_WIDTH);
    localparam logic [XW-1:0] X_SAT    = XW'(SENSOR_WIDTH + 1);
    localparam logic [YW-1:0] Y_LEN    = YW'(SENSOR_HEIGHT);
    localparam logic [XW-1:0] X_MASK   = XW'((1 << X_DECIM_LOG2) - 1);
    localparam logic [YW-1:0] Y_MASK   = YW'((1 << Y_DECIM_LOG2) - 1);
    localparam logic [BW-1:0] ROW_STEP = BW'(IMG_WIDTH);
    localparam logic [31:0]   IMG_W_U  = 32'(IMG_WIDTH);
    localparam logic [31:0]   IMG_H_U  = 32'(IMG_HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_VBLANK,
        S_ACTIVE
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [BW-1:0]         row_base_q, row_base_d;
    logic                  tog_q, tog_d;
    logic                  href_q, href_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [23:0]           wdata_q, wdata_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic [31:0] col32;
    logic [31:0] row32;
    logic        row_ok;
    logic        pix_ok;
    logic [23:0] pix_data;

    always_comb begin
        col32  = 32'(x_q >> X_DECIM_LOG2);
        row32  = 32'(y_q >> Y_DECIM_LOG2);
        row_ok = ((y_q & Y_MASK) == '0) && (y_q < Y_LEN)
              && (row32 < IMG_H_U);
        pix_ok = row_ok && ((x_q & X_MASK) == '0) && (x_q < X_LEN)
              && (col32 < IMG_W_U);
    end

`ifdef CAP_TEST_PATTERN_EN
    logic unused_pat;
    assign unused_pat = ^{fmt, data};

    always_comb begin
        pix_data = {col32[7:0], row32[7:0], 8'h5A};
    end
`else
    logic [7:0] hi_q, hi_d;
    logic [1:0] fmt_q, fmt_d;

    always_comb begin
        hi_d  = hi_q;
        fmt_d = fmt_q;
        if (state_q == S_ACTIVE && !vsync && href && !tog_q) begin
            hi_d = data;
        end
        if (state_q == S_VBLANK && !vsync) begin
            fmt_d = fmt;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q  <= '0;
            fmt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            fmt_q <= fmt_d;
        end
    end

    always_comb begin
        unique case (fmt_q)
            2'd1:    pix_data = {hi_q[3:0], 4'h0, data[7:4], 4'h0,
                                 data[3:0], 4'h0};
            2'd2:    pix_data = {hi_q, hi_q, hi_q};
            default: pix_data = {hi_q[7:3], 3'b000, hi_q[2:0], data[7:5],
                                 2'b00, data[4:0], 3'b000};
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        tog_d      = tog_q;
        href_d     = href_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (cap_en) begin
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!cap_en) begin
                    state_d = S_IDLE;
                end else if (vsync) begin
                    state_d = S_VBLANK;
                end
            end
            S_VBLANK: begin
                if (!vsync) begin
                    state_d    = S_ACTIVE;
                    x_d        = '0;
                    y_d        = '0;
                    row_base_d = '0;
                    tog_d      = 1'b0;
                    href_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (vsync) begin
                    done_d  = 1'b1;
                    href_d  = 1'b0;
                    state_d = cap_en ? S_VBLANK : S_IDLE;
                end else begin
                    href_d = href;
                    if (href) begin
                        tog_d = !tog_q;
                        if (tog_q) begin
                            if (x_q != X_SAT) begin
                                x_d = x_q + XW'(1);
                            end
                            if (pix_ok) begin
                                we_d    = 1'b1;
                                waddr_d = ADDR_WIDTH'(row_base_q + BW'(col32));
                                wdata_d = pix_data;
                            end
                        end
                    end else if (href_q) begin
                        // falling href closes the line; row base follows y, not pixel count
                        x_d   = '0;
                        tog_d = 1'b0;
                        if (y_q != Y_LEN) begin
                            y_d = y_q + YW'(1);
                        end
                        if (tog_q || x_q != X_LEN || y_q == Y_LEN) begin
                            err_d = 1'b1;
                        end
                        if (row_ok) begin
                            row_base_d = row_base_q + ROW_STEP;
                        end
                    end
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            tog_q      <= 1'b0;
            href_q     <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            tog_q      <= tog_d;
            href_q     <= href_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign we         = we_q;
    assign wAddr      = waddr_q;
    assign wData      = wdata_q;
    assign frame_done = done_q;
    assign busy       = busy_q;
    assign err_line   = err_q;

endmodule

// File: tb/tb_ov7670_capture_win.sv
// Directed/random frame bench for ov7670_capture_win against a pixel-level reference model.
// Two instances share stimulus: IMG 4x2 and IMG 2x1 (clipping), both SENSOR 8x4.
module tb_ov7670_capture_win;

    localparam int SW = 8;
    localparam int SH = 4;
    localparam int IW = 4;
    localparam int IH = 2;

    logic       pclk = 1'b0;
    logic       reset_n;
    logic       cap_en;
    logic [1:0] fmt;
    logic       href;
    logic       vsync;
    logic [7:0] data;

    logic        we_a, fd_a, busy_a, err_a;
    logic [2:0]  addr_a;
    logic [23:0] wd_a;
    logic        we_b, fd_b, busy_b, err_b;
    logic [0:0]  addr_b;
    logic [23:0] wd_b;

    ov7670_capture_win #(
        .SENSOR_WIDTH(SW), .SENSOR_HEIGHT(SH), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
        .X_DECIM_LOG2(1), .Y_DECIM_LOG2(1)
    ) dut_a (
        .pclk(pclk), .reset_n(reset_n), .cap_en(cap_en), .fmt(fmt),
        .href(href), .vsync(vsync), .data(data), .we(we_a), .wAddr(addr_a),
        .wData(wd_a), .frame_done(fd_a), .busy(busy_a), .err_line(err_a)
    );

    ov7670_capture_win #(
        .SENSOR_WIDTH(SW), .SENSOR_HEIGHT(SH), .IMG_WIDTH(2), .IMG_HEIGHT(1),
        .X_DECIM_LOG2(1), .Y_DECIM_LOG2(1)
    ) dut_b (
        .pclk(pclk), .reset_n(reset_n), .cap_en(cap_en), .fmt(fmt),
        .href(href), .vsync(vsync), .data(data), .we(we_b), .wAddr(addr_b),
        .wData(wd_b), .frame_done(fd_b), .busy(busy_b), .err_line(err_b)
    );

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    logic [63:0] obs_a[$], obs_b[$], exp_a[$], exp_b[$];
    int          fdc_a = 0, fdc_b = 0, exp_fd = 0;
    int          last_addr_a = 0;
    logic [23:0] last_data_a = '0;

    int         ly = 0, lx = 0;
    bit         captured = 0, err_exp = 0;
    logic [1:0] frm_fmt = 2'd0;
    bit         fix_en = 0;
    logic [7:0] fix_h = '0, fix_l = '0;
    int         chg_line = -1;
    logic [1:0] chg_fmt = 2'd0;
    bit         chg_cap = 1;

    always @(negedge pclk) begin
        if (we_a) begin
            obs_a.push_back({32'(addr_a), 8'h00, wd_a});
            last_addr_a = 32'(addr_a);
            last_data_a = wd_a;
        end
        if (we_b) obs_b.push_back({32'(addr_b), 8'h00, wd_b});
        if (fd_a) fdc_a++;
        if (fd_b) fdc_b++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_px(input logic [1:0] f,
        input logic [7:0] h, input logic [7:0] l, input int col, input int row);
        int p, v;
`ifdef CAP_TEST_PATTERN_EN
        v = ((col & 255) << 16) | ((row & 255) << 8) | 'h5A;
`else
        p = int'(h) * 256 + int'(l);
        if (f == 2'd1)
            v = (((p >> 8) & 15) << 20) | (((p >> 4) & 15) << 12) | ((p & 15) << 4);
        else if (f == 2'd2)
            v = int'(h) * 65793;
        else
            v = ((p >> 11) << 19) | (((p >> 5) & 63) << 10) | ((p & 31) << 3);
`endif
        return 24'(v);
    endfunction

    task automatic send_pix(input logic [7:0] h, input logic [7:0] l);
        int col, row;
        @(posedge pclk); #1; href = 1'b1; data = h;
        @(posedge pclk); #1; data = l;
        if (captured && ly < SH && lx < SW && lx % 2 == 0 && ly % 2 == 0) begin
            col = lx / 2;
            row = ly / 2;
            if (col < IW && row < IH)
                exp_a.push_back({32'(row * IW + col), 8'h00,
                                 model_px(frm_fmt, h, l, col, row)});
            if (col < 2 && row < 1)
                exp_b.push_back({32'(col), 8'h00,
                                 model_px(frm_fmt, h, l, col, row)});
        end
        lx++;
    endtask

    task automatic send_line(input int npix, input bit extra);
        logic [7:0] h, l;
        for (int i = 0; i < npix; i++) begin
            h = fix_en ? fix_h : 8'($urandom_range(0, 255));
            l = fix_en ? fix_l : 8'($urandom_range(0, 255));
            send_pix(h, l);
        end
        if (extra) begin
            @(posedge pclk); #1; href = 1'b1; data = 8'($urandom_range(0, 255));
        end
        @(posedge pclk); #1; href = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        if (lx != SW || extra || ly >= SH) err_exp = 1;
        ly++;
        lx = 0;
    endtask

    task automatic vs_pulse();
        @(posedge pclk); #1; href = 1'b0; vsync = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        if (captured) exp_fd++;
        captured = cap_en;
        frm_fmt  = fmt;
        ly = 0;
        lx = 0;
        err_exp = 0;
        vsync = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
    endtask

    task automatic check_q(input string tag);
        int n;
        chk({tag, "_cnt_a"}, 64'(obs_a.size()), 64'(exp_a.size()));
        chk({tag, "_cnt_b"}, 64'(obs_b.size()), 64'(exp_b.size()));
        n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) chk({tag, "_wr_a"}, obs_a[i], exp_a[i]);
        n = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) chk({tag, "_wr_b"}, obs_b[i], exp_b[i]);
        obs_a.delete(); obs_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic run_frame(input string tag, input int nlines,
        input int bad_line, input int bad_len, input int odd_line);
        for (int l = 0; l < nlines; l++) begin
            if (l == chg_line) begin
                fmt = chg_fmt;
                cap_en = chg_cap;
            end
            send_line((l == bad_line) ? bad_len : SW, l == odd_line);
        end
        if (captured) begin
            chk({tag, "_err_a"}, 64'(err_a), 64'(err_exp));
            chk({tag, "_err_b"}, 64'(err_b), 64'(err_exp));
        end
        chg_line = -1;
        vs_pulse();
        chk({tag, "_fd_a"}, 64'(fdc_a), 64'(exp_fd));
        chk({tag, "_fd_b"}, 64'(fdc_b), 64'(exp_fd));
        check_q(tag);
    endtask

    initial begin
        reset_n = 1'b0; cap_en = 1'b0; fmt = 2'd0;
        href = 1'b0; vsync = 1'b0; data = 8'h00;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_we", 64'(we_a), 64'd0);
        chk("rst_addr", 64'(addr_a), 64'd0);
        chk("rst_data", 64'(wd_a), 64'd0);
        chk("rst_fd", 64'(fd_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        chk("idle_busy", 64'(busy_a), 64'd0);

        cap_en = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        chk("sync_busy", 64'(busy_a), 64'd1);
        vs_pulse();

        fix_en = 1; fix_h = 8'hF8; fix_l = 8'h1F;
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < SH; l++) send_line(SW, 0);
            chk("t1_err", 64'(err_a), 64'd0);
            vs_pulse();
            chk("t1_fd", 64'(fdc_a), 64'(exp_fd));
            chk("t1_cnt", 64'(obs_a.size()), 64'd8);
            chk("t1_last_addr", 64'(last_addr_a), 64'd7);
`ifdef CAP_TEST_PATTERN_EN
            chk("t1_last_data", 64'(last_data_a), 64'h03015A);
`else
            chk("t1_last_data", 64'(last_data_a), 64'hF800F8);
`endif
            check_q("t1");
        end

        fmt = 2'd1;
        vs_pulse();
        fix_h = 8'h0A; fix_l = 8'h5C;
        run_frame("t2_444", SH, -1, 0, -1);
`ifndef CAP_TEST_PATTERN_EN
        chk("t2_444_const", 64'(last_data_a), 64'hA050C0);
`endif
        fmt = 2'd2;
        vs_pulse();
        fix_h = 8'h80; fix_l = 8'h33;
        run_frame("t2_gray", SH, -1, 0, -1);
`ifndef CAP_TEST_PATTERN_EN
        chk("t2_gray_const", 64'(last_data_a), 64'h808080);
`endif

        fix_en = 0;
        fmt = 2'd0;
        vs_pulse();
        chg_line = 1; chg_fmt = 2'd1; chg_cap = 1;
        run_frame("t2_midfmt", SH, -1, 0, -1);
        run_frame("t2_nextfmt", SH, -1, 0, -1);
        fmt = 2'd3;
        vs_pulse();
        run_frame("t2_fmt3", SH, -1, 0, -1);

        run_frame("t3_short", SH, 1, 5, -1);
        run_frame("t3_clear", SH, -1, 0, -1);
        run_frame("t3_odd", SH, -1, 0, 3);
        run_frame("t3_tall", SH + 1, -1, 0, -1);
        run_frame("t3_long", SH, 2, SW + 1, -1);

        chg_line = 2; chg_cap = 0; chg_fmt = fmt;
        run_frame("t5_stop", SH, -1, 0, -1);
        chk("t5_idle_busy", 64'(busy_a), 64'd0);
        chg_line = 1; chg_cap = 1; chg_fmt = fmt;
        run_frame("t5_arm", SH, -1, 0, -1);
        chk("t5_armed_busy", 64'(busy_a), 64'd1);
        run_frame("t5_resume", SH, -1, 0, -1);

        for (int i = 0; i < 3; i++)
            send_pix(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        @(posedge pclk); #1; data = 8'($urandom_range(0, 255));
        @(posedge pclk); #1; reset_n = 1'b0;
        #1;
        chk("t5_rst_we", 64'(we_a), 64'd0);
        chk("t5_rst_addr", 64'(addr_a), 64'd0);
        chk("t5_rst_data", 64'(wd_a), 64'd0);
        chk("t5_rst_busy", 64'(busy_a), 64'd0);
        chk("t5_rst_err", 64'(err_a), 64'd0);
        chk("t5_rst_fd", 64'(fd_a), 64'd0);
        @(posedge pclk); #1; reset_n = 1'b1; href = 1'b0;
        captured = 0;
        check_q("t5_pre_rst");
        ly = 1; lx = 0;
        run_frame("t5_after_rst", 3, -1, 0, -1);
        run_frame("t5_full", SH, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
